// File: rtl/bmm_pkg.sv
// Shared constants for byte_mask_ram.
// Optional build macro BMM_OUT_REG_EN adds a read output register stage
// (read latency 2, response queue depth 4); without it latency is 1, depth 3.
package bmm_pkg;

`ifdef BMM_OUT_REG_EN
  localparam int BMM_LATENCY = 2;
`else
  localparam int BMM_LATENCY = 1;
`endif

  // One credit per pipeline stage plus two so a held-high rsp_ready sustains one read per cycle
  localparam int BMM_RSP_DEPTH = BMM_LATENCY + 2;
  localparam int BMM_CNT_W     = $clog2(BMM_RSP_DEPTH + 1);

  // Number of byte lanes in a data word
  function automatic int bmm_lanes(input int data_w);
    return data_w / 8;
  endfunction

  typedef logic [7:0] bmm_byte_t;

endpackage

// File: rtl/bmm_rsp_fifo.sv
// Small synchronous response FIFO with push/pop/count. Entries are a
// DATA_W-wide read-data record; o_data reads as zero whenever empty.
module bmm_rsp_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [W-1:0]     o_data,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [W-1:0] rdata;
  } rsp_entry_t;

  rsp_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  // Depth need not be a power of two, so pointers wrap explicitly
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_valid = (r_count != '0);
  assign w_pop   = i_pop && o_valid;
  assign o_data  = o_valid ? r_mem[r_rd_ptr].rdata : '0;
  assign o_count = r_count;

  // Entry storage; the credit scheme upstream guarantees no push when full
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr].rdata <= i_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      if (i_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_mask_ram.sv
// Single-port byte-masked RAM with valid/ready requests and an in-order,
// credit-managed read response queue. Define BMM_OUT_REG_EN to insert an
// output register after the RAM read (latency 2 instead of 1).
module byte_mask_ram
  import bmm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NB     = bmm_lanes(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NB-1:0]     req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata
);

  localparam int RES_W = BMM_CNT_W + 1;

  logic                 w_acc;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic [DATA_W-1:0]    w_ram_q;
  logic                 r_rd_v0;
  logic                 w_push;
  logic [DATA_W-1:0]    w_push_data;
  logic [1:0]           w_inflight;
  logic [BMM_CNT_W-1:0] w_count;
  logic [RES_W-1:0]     w_reserved;

  assign w_acc    = req_valid && req_ready;
  assign w_wr_acc = w_acc && req_wr;
  assign w_rd_acc = w_acc && !req_wr;

  // Every accepted read owns a queue slot from acceptance until it is popped
  assign w_reserved = RES_W'(w_count) + RES_W'(w_inflight);
  assign req_ready  = !rst && (w_reserved < RES_W'(BMM_RSP_DEPTH));

  // One narrow RAM per byte lane so each lane write enable maps onto its own array
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    bmm_byte_t r_mem [DEPTH];
    bmm_byte_t r_q;

    // Lane write when enabled; registered read of the addressed word on a read
    always_ff @(posedge clk) begin
      if (w_wr_acc && req_be[gi]) begin
        r_mem[req_addr] <= req_wdata[8*gi +: 8];
      end
      if (w_rd_acc) begin
        r_q <= r_mem[req_addr];
      end
    end

    assign w_ram_q[8*gi +: 8] = r_q;
  end

  // Marks that the RAM output register holds a read result this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_v0 <= 1'b0;
    end else begin
      r_rd_v0 <= w_rd_acc;
    end
  end

`ifdef BMM_OUT_REG_EN
  logic              r_rd_v1;
  logic [DATA_W-1:0] r_out_q;

  // Second pipeline valid flag behind the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_v1 <= 1'b0;
    end else begin
      r_rd_v1 <= r_rd_v0;
    end
  end

  // Output register capturing RAM read data
  always_ff @(posedge clk) begin
    if (r_rd_v0) begin
      r_out_q <= w_ram_q;
    end
  end

  assign w_push      = r_rd_v1;
  assign w_push_data = r_out_q;
  assign w_inflight  = {1'b0, r_rd_v0} + {1'b0, r_rd_v1};
`else
  assign w_push      = r_rd_v0;
  assign w_push_data = w_ram_q;
  assign w_inflight  = {1'b0, r_rd_v0};
`endif

  bmm_rsp_fifo #(
    .W     (DATA_W),
    .DEPTH (BMM_RSP_DEPTH),
    .CNT_W (BMM_CNT_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (rsp_ready),
    .o_valid (rsp_valid),
    .o_data  (rsp_rdata),
    .o_count (w_count)
  );

endmodule
